// File: rtl/cla_add_pipe.sv
// Pipelined carry-lookahead adder/subtractor: {cout,res} = a + (sub ? ~b : b) + (sub ? 1 : cin), plus signed overflow.
// Latency: STAGES register stages; a beat offered in cycle c is presented on the outputs in cycle c+STAGES when not stalled.
// Backpressure: full valid/ready; a stage loads when empty or when its successor loads; outputs hold while out_valid && !out_ready.
module cla_add_pipe #(
  parameter int N      = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         cout,
  output logic         ovf
);

  // Number of lookahead groups; the top group is partial when N is not a multiple of GROUP.
  localparam int NG = (N + GROUP - 1) / GROUP;
  // With one stage everything is combinational into a single result register;
  // otherwise stage 0 holds generate/propagate and the rest hold the finished sum.
  localparam int NR        = (STAGES == 1) ? 1 : STAGES - 1;
  localparam int FIRST_SUM = STAGES - NR;

  typedef struct packed {
    logic [N-1:0] p;
    logic [N-1:0] g;
    logic         ci;
    logic         a_msb;
    logic         bb_msb;
  } pg_t;

  typedef struct packed {
    logic [N-1:0] res;
    logic         cout;
    logic         ovf;
  } sum_t;

  logic [N-1:0]      bb;
  pg_t               pg_in;
  pg_t               pg_src;
  sum_t              sum_c;
  logic [NG-1:0]     grp_g;
  logic [NG-1:0]     grp_p;
  logic [NG:0]       grp_c;
  logic [N-1:0]      bit_c;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vld_src;
  logic [STAGES-1:0] load;
  sum_t              sr [NR];

  // Operand conditioning: subtract is a + ~b + 1, so cin is ignored in subtract mode.
  always_comb begin
    bb            = sub ? ~b : b;
    pg_in.p       = a ^ bb;
    pg_in.g       = a & bb;
    pg_in.ci      = sub | cin;
    pg_in.a_msb   = a[N-1];
    pg_in.bb_msb  = bb[N-1];
  end

  generate
    if (STAGES == 1) begin : g_src_comb
      assign pg_src = pg_in;
    end else begin : g_src_reg
      pg_t pg_q;
      // First stage captures per-bit generate/propagate, the carry-in and the sign bits.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pg_q <= '0;
        else if (load[0]) pg_q <= pg_in;
      end
      assign pg_src = pg_q;
    end
  endgenerate

  // Group generate/propagate, folded from the low bit of each group upward.
  always_comb begin
    grp_g = '0;
    grp_p = '1;
    for (int i = 0; i < N; i++) begin
      grp_g[i/GROUP] = pg_src.g[i] | (pg_src.p[i] & grp_g[i/GROUP]);
      grp_p[i/GROUP] = grp_p[i/GROUP] & pg_src.p[i];
    end
  end

  // Inter-group carries: each one is an independent sum-of-products over the lower groups' G/P and ci.
  always_comb begin
    logic acc;
    logic pp;
    grp_c = '0;
    acc   = 1'b0;
    pp    = 1'b1;
    for (int j = 0; j <= NG; j++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int i = j - 1; i >= 0; i--) begin
        acc = acc | (pp & grp_g[i]);
        pp  = pp & grp_p[i];
      end
      grp_c[j] = acc | (pp & pg_src.ci);
    end
  end

  // Bit carries inside each group start from that group's lookahead carry; sum and flags follow.
  always_comb begin
    logic c;
    bit_c = '0;
    c     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i % GROUP == 0) c = grp_c[i/GROUP];
      bit_c[i] = c;
      c = pg_src.g[i] | (pg_src.p[i] & c);
    end
    sum_c.res  = pg_src.p ^ bit_c;
    sum_c.cout = grp_c[NG];
    sum_c.ovf  = (pg_src.a_msb == pg_src.bb_msb) && (sum_c.res[N-1] != pg_src.a_msb);
  end

  // Stage k loads when the consumer is taking a beat or any stage at or after k has a hole.
  always_comb begin
    load = '0;
    for (int k = 0; k < STAGES; k++) begin
      load[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!vld[j]) load[k] = 1'b1;
      end
    end
  end

  // Valid source for each stage: the input for stage 0, the previous stage otherwise.
  always_comb begin
    vld_src    = vld << 1;
    vld_src[0] = in_valid;
  end

  assign in_ready = load[0];

  // Stage valid bits; reset drops every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) vld[k] <= vld_src[k];
      end
    end
  end

  // Result registers: first one captures the computed sum, the rest are pure delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) sr[r] <= '0;
    end else begin
      if (load[FIRST_SUM]) sr[0] <= sum_c;
      for (int r = 1; r < NR; r++) begin
        if (load[FIRST_SUM + r]) sr[r] <= sr[r-1];
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign res       = sr[NR-1].res;
  assign cout      = sr[NR-1].cout;
  assign ovf       = sr[NR-1].ovf;

endmodule

// File: tb/tb_cla_add_pipe.sv
// Self-checking bench for cla_add_pipe with N=8, GROUP=4, STAGES=2.
// Directed vector table plus hand-written stall, streaming and reset sequences; a scoreboard checks every beat.
module tb_cla_add_pipe;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] res;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  logic [9:0] sbq [$];
  logic [9:0] sb_exp;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    string      name;
  } vec_t;

  vec_t vecs [9];

  cla_add_pipe #(.N(8), .GROUP(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: {cout, ovf, res}
  function automatic logic [9:0] model(input logic [7:0] fa, input logic [7:0] fb,
                                       input logic fcin, input logic fsub);
    logic [7:0] fbb;
    logic       fci;
    logic [8:0] s;
    logic       fovf;
    fbb  = fsub ? ~fb : fb;
    fci  = fsub ? 1'b1 : fcin;
    s    = {1'b0, fa} + {1'b0, fbb} + {8'd0, fci};
    fovf = (fa[7] == fbb[7]) && (s[7] != fa[7]);
    return {s[8], fovf, s[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled on the falling edge, where transfers for the next rising edge are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_count++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_beat: got res 0x%0h with no beat outstanding", res);
        end else begin
          sb_exp = sbq.pop_front();
          chk("sb_result", {22'd0, cout, ovf, res}, {22'd0, sb_exp});
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(a, b, cin, sub));
    end
  end

  // Offer one beat and hold it until accepted (bounded).
  task automatic offer_and_wait(input logic [7:0] va, input logic [7:0] vb,
                                input logic vcin, input logic vsub, output bit ok);
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
  endtask

  // Single beat through an idle pipe: absent one cycle after acceptance, present the next.
  task automatic apply(input vec_t v);
    bit ok;
    offer_and_wait(v.a, v.b, v.cin, v.sub, ok);
    @(negedge clk);
    chk({v.name, "_early"}, out_valid, 0);
    tick();
    @(negedge clk);
    chk({v.name, "_valid"}, out_valid, 1);
    chk({v.name, "_res"}, res, v.res);
    chk({v.name, "_cout"}, cout, v.cout);
    chk({v.name, "_ovf"}, ovf, v.ovf);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int nb;
    int gaps;
    int start_count;
    vec_t extra;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01"};
    vecs[1] = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_cin"};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_7f_01"};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_80_80"};
    vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07"};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01"};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "sub_00_00"};
    vecs[7] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, "add_7f_7f_cin"};
    vecs[8] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "prop_55_aa_cin"};

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 8'h00);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    // Asynchronous reset mid-stall: a stalled beat vanishes immediately
    out_ready = 1'b0;
    offer_and_wait(8'hC0, 8'h90, 1'b0, 1'b0, ok);
    tick();
    @(negedge clk);
    chk("stall_valid", out_valid, 1);
    chk("stall_res", res, 8'h50);
    chk("stall_cout", cout, 1);
    chk("stall_ovf", ovf, 1);
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_res", res, 8'h00);
    chk("async_rst_cout", cout, 0);
    chk("async_rst_ovf", ovf, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_no_ghost", out_valid, 0);
    tick();

    // Directed arithmetic table
    for (int i = 0; i < 9; i++) apply(vecs[i]);

    // Backpressure: with the consumer stalled only two beats fit
    out_ready = 1'b0;
    nb = 0;
    for (int c = 0; c < 6; c++) begin
      a = 8'(nb + 1); b = 8'(nb + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) nb++;
      if (c >= 2) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_res", res, 8'h02);
      end
      tick();
    end
    chk("bp_accepted", nb, 2);
    // Release: drain and refill in the same cycle, results back-to-back in order
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (nb < 4) begin
        a = 8'(nb + 1); b = 8'(nb + 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 0) chk("bp_full_accept", in_ready, 1);
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_res", res, 2 * (c + 1));
      if (in_valid && in_ready) nb++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_total_accepted", nb, 4);
    tick();

    // Streaming throughput
    gaps = 0;
    start_count = out_count;
    for (int i = 0; i < 258; i++) begin
      if (i < 256) begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 2 && !out_valid) gaps++;
      if (i < 256 && !in_ready) gaps++;
      tick();
    end
    chk("stream_gaps", gaps, 0);
    chk("stream_count", out_count - start_count, 256);

    // Reset with two beats in flight
    out_ready = 1'b1;
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    a = 8'h30; b = 8'h40;
    tick();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("midflight_rst_valid", out_valid, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midflight_no_ghost", out_valid, 0);
      tick();
    end
    extra = '{8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, "post_rst_beat"};
    apply(extra);

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
